p09_timing: RTL and testbench
=============================

Name: p09_timing

Overview:
- Raster timing generator for the p09 video pipeline. Sits directly upstream of the background, sprite and colour stages.
- Produces signed horizontal/vertical position counters, registered sync and blanking strobes, line/frame pulses, and the 8-bit animation time `cur_time`.
- Downstream consumers use its outputs combinationally; every output is registered, and all outputs are mutually aligned in every cycle.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- Derived localparams: HTOTAL = sum of H terms (800); VTOTAL = sum of V terms (525); H_BLANK = HTOTAL - H_DISPLAY; V_BLANK = VTOTAL - V_DISPLAY.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- time_run  in  1  1 = `cur_time` advances once per frame; 0 = `cur_time` frozen
- counter_h  out  $clog2(HTOTAL)+1 signed  horizontal position; visible when >= 0
- counter_v  out  $clog2(VTOTAL)+1 signed  vertical position; visible when >= 0
- hsync  out  1  horizontal sync at SYNC_POL level
- vsync  out  1  vertical sync at SYNC_POL level
- display_on  out  1  1 when counter_h >= 0 and counter_v >= 0
- line_start  out  1  one-cycle pulse when counter_h = -H_BLANK
- frame_start  out  1  one-cycle pulse when counter_h = -H_BLANK and counter_v = -V_BLANK
- cur_time  out  8  animation time

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - counter_h = -H_BLANK (-160), counter_v = -V_BLANK (-45)
  - hsync and vsync inactive (= ~SYNC_POL)
  - display_on = 0, line_start = 0, frame_start = 0, cur_time = 0
- First cycle after release (first rising edge with rst_n = 1): counters advance to (-159, -45). The origin cycle is not re-flagged by line_start or frame_start.
- Horizontal sequence (defaults):
  - front porch -160..-145
  - sync -144..-49
  - back porch -48..-1
  - display 0..639
  - at 639 the counter wraps to -160
- Vertical counter advances only on the cycle the horizontal counter wraps. Vertical sequence (defaults):
  - front porch -45..-36
  - sync -35..-34
  - back porch -33..-1
  - display 0..479
  - at 479 the counter wraps to -45
- Strobe timing: hsync, vsync, display_on, line_start and frame_start are computed from next-state counter values and registered, so each describes the counter value presented in the same cycle. Zero-cycle skew between counters and strobes.
- hsync active iff counter_h lies in [-H_SYNC-H_BACK, -H_BACK-1]. vsync active iff counter_v lies in [-V_SYNC-V_BACK, -V_BACK-1]. vsync changes only on a line boundary.
- cur_time update:
  - Updated on the same edge the counters wrap to the frame origin (the edge that raises frame_start).
  - If time_run = 1: cur_time <= cur_time + 1 (mod 256; 255 wraps to 0).
  - If time_run = 0: hold.
  - time_run is sampled only on that edge; changes mid-frame take effect at the next frame boundary.
- Arithmetic: counters are two's complement at the declared width; no saturation. Wrap values are derived only from the parameters.

Optional Feature:
- Macro: P09_TIME_DIV_EN
- Defined:
  - Adds input time_div [1:0] and an internal 3-bit frame prescaler, reset to 0.
  - With time_run = 1, cur_time increments on a frame wrap only when prescaler[time_div-1:0] == all-ones (time_div = 0: every frame), i.e. every 2^time_div frames. The prescaler increments every frame regardless.
  - With time_run = 0, both cur_time and the prescaler hold.
- Undefined: no time_div port and no prescaler; behaviour exactly as in Behaviour.

Decomposition:
- Package p09_pkg holds:
  - default timing localparams (640x480 values)
  - helper function for the counter width
  - SYNC_POL default
- Sub-module p09_axis_counter, instanced twice (horizontal, vertical):
  - parameters: DISPLAY, FRONT, SYNC, BACK
  - ports: advance (input), count, sync, wrap (outputs)
  - Vertical instance `advance` = horizontal instance `wrap`.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles, then release -> before release counter_h = -160, counter_v = -45, hsync = vsync = 1, cur_time = 0. First cycle after release: counter_h = -159.
- Line timing: run one line -> hsync low for exactly 96 cycles starting at counter_h = -144; display_on high for 640 cycles starting at counter_h = 0 once counter_v >= 0; line_start period = 800 cycles.
- Frame timing: run 2 frames -> frame_start period = 420000 cycles; vsync low for exactly 1600 cycles starting at counter_v = -35, counter_h = -160.
- Animation: time_run = 1 for 256 frames -> cur_time increments by 1 per frame and wraps 255 -> 0. Drop time_run mid-frame -> cur_time holds starting at the next frame boundary.
- Async reset mid-frame: assert rst_n at counter_h = 100, counter_v = 200, between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.
- With P09_TIME_DIV_EN and time_div = 2: 16 frames -> cur_time = 4.

Source files
------------

// File: rtl/p09_pkg.sv
// p09 raster timing: shared defaults, the counter-width helper and the strobe bundle.
package p09_pkg;

    // Default 640x480 timing, in pixels (horizontal) and lines (vertical).
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Sync active level: 0 = active-low.
    localparam bit DEF_SYNC_POL  = 1'b0;

    // Signed counter width able to hold -blank .. display-1 for an axis of 'total' steps.
    function automatic int cnt_width(input int total);
        return $clog2(total) + 1;
    endfunction

    // Strobes derived from both axes, registered together in the top.
    typedef struct packed {
        logic display_on;
        logic line_start;
        logic frame_start;
    } strobe_t;

endpackage

// File: rtl/p09_axis_counter.sv
// One raster axis: signed position counter running -BLANK .. DISPLAY-1 and its
// registered sync strobe. The next-state count is exported so the top can register
// strobes that line up with the count presented in the same cycle.
module p09_axis_counter
    import p09_pkg::*;
#(
    parameter int DISPLAY  = DEF_H_DISPLAY,
    parameter int FRONT    = DEF_H_FRONT,
    parameter int SYNC     = DEF_H_SYNC,
    parameter int BACK     = DEF_H_BACK,
    parameter bit SYNC_POL = DEF_SYNC_POL,
    parameter int W        = cnt_width(DISPLAY + FRONT + SYNC + BACK)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
    output logic signed [W-1:0] count,
    output logic signed [W-1:0] count_next,
    output logic                sync,
    output logic                wrap
);

    localparam int BLANK = FRONT + SYNC + BACK;

    // Key positions on the axis, all derived from the timing parameters.
    localparam logic signed [W-1:0] L_ORIGIN     = W'(-BLANK);
    localparam logic signed [W-1:0] L_LAST       = W'(DISPLAY - 1);
    localparam logic signed [W-1:0] L_SYNC_FIRST = W'(-(SYNC + BACK));
    localparam logic signed [W-1:0] L_SYNC_LAST  = W'(-BACK - 1);
    localparam logic signed [W-1:0] L_ONE        = W'(1);

    logic signed [W-1:0] r_count;
    logic                r_sync;
    logic signed [W-1:0] w_count_next;
    logic                w_wrap;
    logic                w_sync_active;

    // The axis wraps when it is told to advance from its last visible position.
    assign w_wrap = advance && (r_count == L_LAST);

    // Next-state position: hold, step by one, or return to the origin.
    always_comb begin
        w_count_next = r_count;
        if (w_wrap) begin
            w_count_next = L_ORIGIN;
        end else if (advance) begin
            w_count_next = r_count + L_ONE;
        end
    end

    assign w_sync_active = (w_count_next >= L_SYNC_FIRST) && (w_count_next <= L_SYNC_LAST);

    // Position and sync are registered together so they never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= L_ORIGIN;
            r_sync  <= ~SYNC_POL;
        end else begin
            r_count <= w_count_next;
            r_sync  <= w_sync_active ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign count      = r_count;
    assign count_next = w_count_next;
    assign sync       = r_sync;
    assign wrap       = w_wrap;

endmodule

// File: rtl/p09_timing.sv
// p09 raster timing generator: signed h/v position counters, sync/blank strobes,
// line/frame pulses and the per-frame animation time cur_time.
// Optional build macro P09_TIME_DIV_EN adds input time_div and a 3-bit frame
// prescaler so cur_time advances once every 2^time_div frames.
module p09_timing
    import p09_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = DEF_SYNC_POL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic time_run,
`ifdef P09_TIME_DIV_EN
    input  logic [1:0] time_div,
`endif
    output logic signed [cnt_width(H_DISPLAY + H_FRONT + H_SYNC + H_BACK)-1:0] counter_h,
    output logic signed [cnt_width(V_DISPLAY + V_FRONT + V_SYNC + V_BACK)-1:0] counter_v,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] cur_time
);

    localparam int HTOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VTOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_BLANK = HTOTAL - H_DISPLAY;
    localparam int V_BLANK = VTOTAL - V_DISPLAY;
    localparam int HW      = cnt_width(HTOTAL);
    localparam int VW      = cnt_width(VTOTAL);

    localparam logic signed [HW-1:0] L_H_ORIGIN = HW'(-H_BLANK);
    localparam logic signed [VW-1:0] L_V_ORIGIN = VW'(-V_BLANK);

    logic signed [HW-1:0] w_h_count;
    logic signed [HW-1:0] w_h_next;
    logic                 w_h_sync;
    logic                 w_h_wrap;
    logic signed [VW-1:0] w_v_count;
    logic signed [VW-1:0] w_v_next;
    logic                 w_v_sync;
    logic                 w_v_wrap;

    strobe_t              w_strobe_next;
    strobe_t              r_strobe;
    logic [7:0]           r_cur_time;
    logic                 w_time_tick;

    // Horizontal axis advances every pixel clock.
    p09_axis_counter #(
        .DISPLAY  (H_DISPLAY),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .SYNC_POL (SYNC_POL),
        .W        (HW)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (1'b1),
        .count      (w_h_count),
        .count_next (w_h_next),
        .sync       (w_h_sync),
        .wrap       (w_h_wrap)
    );

    // Vertical axis advances only when the horizontal axis wraps, so its wrap
    // marks the edge that returns both counters to the frame origin.
    p09_axis_counter #(
        .DISPLAY  (V_DISPLAY),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .SYNC_POL (SYNC_POL),
        .W        (VW)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (w_h_wrap),
        .count      (w_v_count),
        .count_next (w_v_next),
        .sync       (w_v_sync),
        .wrap       (w_v_wrap)
    );

    // Strobes are decoded from next-state positions so that, once registered,
    // they describe the position shown in the same cycle.
    always_comb begin
        w_strobe_next             = '0;
        w_strobe_next.display_on  = !w_h_next[HW-1] && !w_v_next[VW-1];
        w_strobe_next.line_start  = (w_h_next == L_H_ORIGIN);
        w_strobe_next.frame_start = (w_h_next == L_H_ORIGIN) && (w_v_next == L_V_ORIGIN);
    end

    // Register the combined strobes; reset leaves them all low, so the origin
    // presented straight out of reset is never flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_strobe_next;
        end
    end

`ifdef P09_TIME_DIV_EN
    logic [2:0] r_presc;
    logic [2:0] w_div_mask;

    // Low time_div bits of the prescaler must all be set for cur_time to step.
    assign w_div_mask  = 3'((4'd1 << time_div) - 4'd1);
    assign w_time_tick = ((r_presc & w_div_mask) == w_div_mask);

    // Frame prescaler counts running frames; it freezes with cur_time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 3'd0;
        end else if (w_v_wrap && time_run) begin
            r_presc <= r_presc + 3'd1;
        end
    end
`else
    assign w_time_tick = 1'b1;
`endif

    // Animation time steps on the frame-origin edge; time_run is only looked at there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_time <= 8'd0;
        end else if (w_v_wrap && time_run && w_time_tick) begin
            r_cur_time <= r_cur_time + 8'd1;
        end
    end

    assign counter_h   = w_h_count;
    assign counter_v   = w_v_count;
    assign hsync       = w_h_sync;
    assign vsync       = w_v_sync;
    assign display_on  = r_strobe.display_on;
    assign line_start  = r_strobe.line_start;
    assign frame_start = r_strobe.frame_start;
    assign cur_time    = r_cur_time;

endmodule

// File: tb/tb_p09_timing.sv
// Bench for p09_timing. A small-geometry instance (8x6 total, 48-cycle frame) is
// checked every cycle through a scoreboard; a default 640x480 instance gets
// reset values and first-line timing checks.
`timescale 1ns/1ps
module tb_p09_timing;
    import p09_pkg::*;

    // Small geometry: h = -4..3 (sync -3..-2), v = -4..1 (sync -3..-2).
    localparam int HD = 4, HF = 1, HS = 2, HB = 1;
    localparam int VD = 2, VF = 1, VS = 2, VB = 1;
    localparam int HBL = 4, HT = 8, VBL = 4, VT = 6, FRAME = 48;
    localparam int SHW = cnt_width(HT);
    localparam int SVW = cnt_width(VT);
    localparam int DHW = cnt_width(800);
    localparam int DVW = cnt_width(525);

    logic clk = 1'b0;
    logic rst_n;
    logic time_run;
`ifdef P09_TIME_DIV_EN
    logic [1:0] time_div;
`endif

    logic signed [SHW-1:0] s_h;
    logic signed [SVW-1:0] s_v;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic [7:0] s_t;

    logic signed [DHW-1:0] d_h;
    logic signed [DVW-1:0] d_v;
    logic d_hs, d_vs, d_de, d_ls, d_fs;
    logic [7:0] d_t;

    always #5 clk = ~clk;

    p09_timing #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .time_run(time_run),
`ifdef P09_TIME_DIV_EN
        .time_div(time_div),
`endif
        .counter_h(s_h), .counter_v(s_v), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .line_start(s_ls), .frame_start(s_fs), .cur_time(s_t)
    );

    p09_timing u_def (
        .clk(clk), .rst_n(rst_n), .time_run(1'b0),
`ifdef P09_TIME_DIV_EN
        .time_div(2'd0),
`endif
        .counter_h(d_h), .counter_v(d_v), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .line_start(d_ls), .frame_start(d_fs), .cur_time(d_t)
    );

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        int t;
        int cyc;
    } snap_t;

    snap_t exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference state for the small instance.
    int m_l = 0;       // cycles since the frame origin that followed reset
    int m_t = 0;       // expected cur_time
    int m_presc = 0;   // expected prescaler
    int m_td = 0;      // time_div in effect
    int m_h = -HBL;
    int m_v = -VBL;
    int cyc = 0;
    bit def_done = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One clock: compute what the small DUT must present after this edge and queue it.
    task automatic step();
        snap_t e;
        int mask;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_l = 0; m_t = 0; m_presc = 0;
            e.h = -HBL; e.v = -VBL; e.hs = 1'b1; e.vs = 1'b1;
            e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            m_l++;
            e.h = (m_l % HT) - HBL;
            e.v = ((m_l / HT) % VT) - VBL;
            e.hs = !(e.h >= -(HS + HB) && e.h <= -HB - 1);
            e.vs = !(e.v >= -(VS + VB) && e.v <= -VB - 1);
            e.de = (e.h >= 0) && (e.v >= 0);
            e.ls = (m_l % HT) == 0;
            e.fs = (m_l % FRAME) == 0;
            if (e.fs && time_run) begin
                mask = (1 << m_td) - 1;
                if ((m_presc & mask) == mask) m_t = (m_t + 1) % 256;
                m_presc = (m_presc + 1) % 8;
            end
        end
        e.t = m_t;
        e.cyc = cyc;
        m_h = e.h;
        m_v = e.v;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: the small DUT presents a new raster position every cycle.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(s_h) != e.h || int'(s_v) != e.v || s_hs != e.hs || s_vs != e.vs ||
                    s_de != e.de || s_ls != e.ls || s_fs != e.fs || int'(s_t) != e.t) begin
                    errors++;
                    $display("FAIL cycle %0d raster: got h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b t=%0d, expected h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b t=%0d",
                             e.cyc, s_h, s_v, s_hs, s_vs, s_de, s_ls, s_fs, s_t,
                             e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs, e.t);
                end else if (e.fs) begin
                    $display("frame_start at cycle %0d: cur_time=%0d", e.cyc, e.t);
                end
            end
        end
    end

    // Default 640x480 instance: first line after the initial reset release.
    initial begin
        int hs_low = 0;
        int hs_first = 9999;
        int vs_low = 0;
        int de_cnt = 0;
        int ls_cyc[$];
        @(posedge rst_n);
        @(negedge clk);
        chk("default first counter_h", int'(d_h), -159);
        chk("default first counter_v", int'(d_v), -45);
        for (int c = 0; c < 1700; c++) begin
            if (c < 800 && !d_hs) begin
                if (hs_low == 0) hs_first = int'(d_h);
                hs_low++;
            end
            if (!d_vs) vs_low++;
            if (d_de) de_cnt++;
            if (d_ls) ls_cyc.push_back(c);
            @(negedge clk);
        end
        chk("default hsync start counter_h", hs_first, -144);
        chk("default hsync low cycles", hs_low, 96);
        chk("default vsync low in first lines", vs_low, 0);
        chk("default display_on in blank lines", de_cnt, 0);
        chk("default line_start count", ls_cyc.size(), 2);
        if (ls_cyc.size() == 2) chk("default line_start period", ls_cyc[1] - ls_cyc[0], 800);
        $display("default instance first-line checks done");
        def_done = 1'b1;
    end

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        time_run = 1'b0;
`ifdef P09_TIME_DIV_EN
        time_div = 2'd0;
`endif
        run(5);
        @(negedge clk);
        chk("reset counter_h", int'(s_h), -4);
        chk("reset counter_v", int'(s_v), -4);
        chk("reset hsync", int'(s_hs), 1);
        chk("reset vsync", int'(s_vs), 1);
        chk("reset cur_time", int'(s_t), 0);
        chk("default reset counter_h", int'(d_h), -160);
        chk("default reset counter_v", int'(d_v), -45);
        chk("default reset hsync", int'(d_hs), 1);
        chk("default reset vsync", int'(d_vs), 1);
        #2 rst_n = 1'b1;

        // Frozen time first, then let it run through a full 8-bit wrap.
        run(20);
        @(negedge clk);
        #2 time_run = 1'b1;
        run(FRAME * 255 - 20);
        @(negedge clk);
        chk("cur_time after 255 frames", int'(s_t), 255);
        run(FRAME);
        @(negedge clk);
        chk("cur_time wraps 255->0", int'(s_t), 0);
        run(FRAME * 3);
        @(negedge clk);
        chk("cur_time after 3 more frames", int'(s_t), 3);

        // Drop time_run mid-frame: time freezes from the next frame boundary.
        run(FRAME / 2);
        @(negedge clk);
        #2 time_run = 1'b0;
        run(FRAME * 2);
        @(negedge clk);
        chk("cur_time held with time_run=0", int'(s_t), 3);

        // Asynchronous reset mid-frame at h=2, v=1, between clock edges.
        for (int i = 0; i < FRAME && !(m_h == 2 && m_v == 1); i++) step();
        chk("reached async reset point", m_h * 100 + m_v, 201);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset counter_h", int'(s_h), -4);
        chk("async reset counter_v", int'(s_v), -4);
        chk("async reset display_on", int'(s_de), 0);
        chk("async reset cur_time", int'(s_t), 0);
        chk("async reset default counter_h", int'(d_h), -160);
        run(3);
        @(negedge clk);
        #2 rst_n = 1'b1;
        time_run = 1'b1;
        run(FRAME * 2);
        @(negedge clk);
        chk("cur_time 2 frames after reset", int'(s_t), 2);

`ifdef P09_TIME_DIV_EN
        // Divided time: time_div=2 steps cur_time once every 4 frames.
        #2 rst_n = 1'b0;
        time_div = 2'd2;
        m_td = 2;
        run(3);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(FRAME * 16);
        @(negedge clk);
        chk("cur_time time_div=2 after 16 frames", int'(s_t), 4);
`endif

        @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 0);
        chk("default instance checks completed", int'(def_done), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
